// File: rtl/ledmatrix_pkg.sv
// Purpose: shared types and helpers for the LED matrix frame sequencer.
// Latency: n/a (constants, enum and pure functions only).
// Backpressure: n/a.
// Contents: FRAME_W, frame bit-index helper, sequencer state enum, tick divider.
package ledmatrix_pkg;

  localparam int FRAME_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Bit position of a pixel inside a 64-bit frame.
  function automatic int pix_bit(input int row, input int col);
    return row * 8 + col;
  endfunction

  // Core clocks per hold-time tick.
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Purpose: divides clk down to one tick every TICK_DIV cycles.
// Latency: tick is a combinational decode of the counter; first tick TICK_DIV-1 cycles after reload.
// Backpressure: none; free-running, restarted by reload.
// Ports: clk, rst (sync, active-low), reload (restart count), tick (count==0).
module tick_prescaler #(
  parameter int TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= TOP;
    end else if (reload || (r_cnt == '0)) begin
      r_cnt <= TOP;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/ledmatrix_frame_sequencer.sv
// Purpose: plays up to DEPTH stored 64-bit frames onto the LED matrix pixels bus.
// Latency: start -> LOAD next cycle -> pixels/frame_stb one cycle later; frame period hold*TICK_DIV+1.
// Backpressure: wr_ready only in IDLE with a free slot; start/stop never stall.
// Ports: clk, rst (sync, active-low); wr_valid/wr_ready/wr_data/wr_hold frame load;
//        clear, start, stop, loop controls; busy, frame_idx, frame_stb, pixels status/output.
module ledmatrix_frame_sequencer
  import ledmatrix_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000,
  parameter int DEPTH   = 4,
  parameter int HOLD_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [FRAME_W-1:0]         wr_data,
  input  logic [HOLD_W-1:0]          wr_hold,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   frame_idx,
  output logic                       frame_stb,
  output logic [FRAME_W-1:0]         pixels
);

  localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  state_t r_state, w_state_nxt;

  logic [FRAME_W-1:0] r_data [DEPTH];
  logic [HOLD_W-1:0]  r_hold [DEPTH];

  logic [CW-1:0]      r_count;
  logic [IW-1:0]      r_wr_ptr;
  logic [IW-1:0]      r_frame_idx;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [FRAME_W-1:0] r_pixels;
  logic               r_loop;
  logic               r_busy;
  logic               r_frame_stb;

  logic               w_idle, w_load, w_show;
  logic               w_tick, w_wr_acc, w_start_ok, w_last, w_expire;
  logic [HOLD_W-1:0]  w_slot_hold;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .reload (w_load),
    .tick   (w_tick)
  );

  // Clear beats a same-cycle write; start is judged on the count before any write.
  assign w_wr_acc    = wr_valid && wr_ready && !clear;
  assign w_start_ok  = w_idle && start && !clear && (r_count != '0);
  assign w_last      = ({1'b0, r_frame_idx} == (r_count - CW'(1)));
  assign w_expire    = w_show && w_tick && (r_hold_cnt == HOLD_W'(1));
  assign w_slot_hold = r_hold[r_frame_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; stop outranks expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = stop ? IDLE : SHOW;
      SHOW: begin
        if (stop)          w_state_nxt = IDLE;
        else if (w_expire) w_state_nxt = (w_last && !r_loop) ? IDLE : LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    w_idle    = (r_state == IDLE);
    w_load    = (r_state == LOAD);
    w_show    = (r_state == SHOW);
    wr_ready  = rst && w_idle && (r_count < CW'(DEPTH));
    busy      = r_busy;
    frame_stb = r_frame_stb;
    frame_idx = r_frame_idx;
    pixels    = r_pixels;
  end

  // Frame store: contents need no reset, count/wr_ptr define validity.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_data[r_wr_ptr] <= wr_data;
      r_hold[r_wr_ptr] <= wr_hold;
    end
  end

  // Playback datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_frame_idx <= '0;
      r_hold_cnt  <= '0;
      r_pixels    <= '0;
      r_loop      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_stb <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != IDLE);
      r_frame_stb <= w_load;

      if (w_idle) begin
        if (clear) begin
          r_count  <= '0;
          r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
          r_count  <= r_count + CW'(1);
          r_wr_ptr <= r_wr_ptr + IW'(1);
        end
        if (w_start_ok) begin
          r_loop      <= loop;
          r_frame_idx <= '0;
        end
      end

      // LOAD always presents its frame, even if stop arrives in the same cycle.
      if (w_load) begin
        r_pixels   <= r_data[r_frame_idx];
        r_hold_cnt <= (w_slot_hold == '0) ? HOLD_W'(1) : w_slot_hold;
      end else if (w_show && w_tick) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      end

      if (w_expire && !stop) begin
        if (!w_last)     r_frame_idx <= r_frame_idx + IW'(1);
        else if (r_loop) r_frame_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ledmatrix_frame_sequencer.sv
module tb_ledmatrix_frame_sequencer;
  import ledmatrix_pkg::*;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DEPTH   = 4;
  localparam int HOLD_W  = 16;

  localparam logic [63:0] F_A = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] F_B = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] F_C = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_valid = 1'b0;
  logic [63:0]       wr_data = '0;
  logic [HOLD_W-1:0] wr_hold = '0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic              wr_ready, busy, frame_stb;
  logic [1:0]        frame_idx;
  logic [63:0]       pixels;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stb_count = 0;

  typedef struct {
    logic [63:0] pix;
    logic [1:0]  idx;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ledmatrix_frame_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEPTH(DEPTH), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_hold(wr_hold), .clear(clear), .start(start),
    .stop(stop), .loop(loop), .busy(busy), .frame_idx(frame_idx),
    .frame_stb(frame_stb), .pixels(pixels)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Scoreboard: every frame_stb must match the next expected frame and cycle.
  initial forever begin
    @(negedge clk);
    if (frame_stb) begin
      stb_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stb: cyc=%0d pixels=%h idx=%0d, required no strobe", cyc, pixels, frame_idx);
      end else begin
        mon_e = exp_q.pop_front();
        if (pixels !== mon_e.pix || frame_idx !== mon_e.idx || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL frame: got pix=%h idx=%0d cyc=%0d, required pix=%h idx=%0d cyc=%0d",
                   pixels, frame_idx, cyc, mon_e.pix, mon_e.idx, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] p, input logic [1:0] i, input int c);
    exp_t e;
    e.pix = p; e.idx = i; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic write_frame(input logic [63:0] d, input logic [HOLD_W-1:0] h, output bit acc);
    wr_valid = 1'b1; wr_data = d; wr_hold = h;
    acc = wr_ready;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic lp);
    start = 1'b1; loop = lp;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_not_busy(input int budget, output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; at = cyc; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b, required 0", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (frame_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b, required 0", frame_stb); end
    checks++; if (pixels !== 64'h0) begin errors++; $display("FAIL reset_pixels: got %h, required 0", pixels); end
    checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d, required 0", frame_idx); end
    rst = 1'b1;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready: got %b, required 1", wr_ready); end
  endtask

  task automatic test_oneshot();
    bit acc; bit ok; int n; int at; int c0; int base;
    n = 0;
    write_frame(F_A, 16'd2, acc); n += int'(acc);
    write_frame(F_B, 16'd1, acc); n += int'(acc);
    write_frame(F_C, 16'd0, acc); n += int'(acc);
    checks++; if (n != 3) begin errors++; $display("FAIL load_handshakes: got %0d, required 3", n); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL load_wr_ready: got %b, required 1", wr_ready); end
    c0 = cyc; base = stb_count;
    push_exp(F_A, 2'd0, c0 + 2);
    push_exp(F_B, 2'd1, c0 + 23);
    push_exp(F_C, 2'd2, c0 + 34);
    pulse_start(1'b0);
    wait_not_busy(200, ok, at);
    checks++; if (!ok || at != c0 + 44) begin errors++; $display("FAIL oneshot_end: ok=%0d busy fell at %0d, required %0d", ok, at, c0 + 44); end
    tick();
    checks++; if (pixels !== F_C || frame_idx !== 2'd2) begin errors++; $display("FAIL oneshot_hold: got %h idx %0d, required %h idx 2", pixels, frame_idx, F_C); end
    checks++; if (stb_count - base != 3) begin errors++; $display("FAIL oneshot_stb_count: got %0d, required 3", stb_count - base); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oneshot_pending: %0d frames never shown, required 0", exp_q.size()); end
  endtask

  task automatic test_loop_stop();
    int c0; int base;
    c0 = cyc;
    push_exp(F_A, 2'd0, c0 + 2);
    push_exp(F_B, 2'd1, c0 + 23);
    push_exp(F_C, 2'd2, c0 + 34);
    push_exp(F_A, 2'd0, c0 + 45);
    push_exp(F_B, 2'd1, c0 + 66);
    pulse_start(1'b1);
    while (cyc < c0 + 70) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy: got %b, required 1", busy); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b, required 0", busy); end
    checks++; if (pixels !== F_B || frame_idx !== 2'd1) begin errors++; $display("FAIL stop_hold: got %h idx %0d, required %h idx 1", pixels, frame_idx, F_B); end
    base = stb_count;
    repeat (40) tick();
    checks++; if (stb_count != base || busy !== 1'b0) begin errors++; $display("FAIL stop_quiet: stb delta %0d busy %b, required 0 and 0", stb_count - base, busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL loop_pending: %0d frames never shown, required 0", exp_q.size()); end
  endtask

  task automatic test_full_busy();
    bit acc; bit ok; int n; int at; int c0;
    logic [63:0] d [5];
    for (int k = 0; k < 5; k++) d[k] = 64'd1 << pix_bit(k, k);
    do_reset();
    n = 0;
    for (int k = 0; k < 4; k++) begin write_frame(d[k], 16'd1, acc); n += int'(acc); end
    checks++; if (n != 4) begin errors++; $display("FAIL full_handshakes: got %0d, required 4", n); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b, required 0", wr_ready); end
    write_frame(d[4], 16'd1, acc);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL fifth_write: accepted=%b, required 0", acc); end
    c0 = cyc;
    for (int k = 0; k < 4; k++) push_exp(d[k], 2'(k), c0 + 2 + 11 * k);
    pulse_start(1'b0);
    tick(); tick(); tick();
    checks++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy_wr_ready: wr_ready %b busy %b, required 0 and 1", wr_ready, busy); end
    pulse_start(1'b1);
    wait_not_busy(200, ok, at);
    checks++; if (!ok || at != c0 + 45) begin errors++; $display("FAIL full_end: ok=%0d busy fell at %0d, required %0d", ok, at, c0 + 45); end
    checks++; if (pixels !== d[3] || exp_q.size() != 0) begin errors++; $display("FAIL full_last: got %h pending %0d, required %h pending 0", pixels, exp_q.size(), d[3]); end
  endtask

  task automatic test_empty_clear();
    bit acc; int base;
    do_reset();
    base = stb_count;
    pulse_start(1'b0);
    tick(); tick();
    checks++; if (busy !== 1'b0 || stb_count != base) begin errors++; $display("FAIL empty_start: busy %b stb delta %0d, required 0 and 0", busy, stb_count - base); end
    write_frame(F_A, 16'd1, acc);
    write_frame(F_B, 16'd1, acc);
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || stb_count != base) begin errors++; $display("FAIL clear_start: busy %b stb delta %0d, required 0 and 0", busy, stb_count - base); end
    pulse_start(1'b0);
    tick(); tick();
    checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL cleared_count: busy %b wr_ready %b, required 0 and 1", busy, wr_ready); end
  endtask

  task automatic test_mid_reset();
    bit acc; bit ok; int at; int c0; int base;
    write_frame(F_A, 16'd3, acc);
    write_frame(F_B, 16'd3, acc);
    c0 = cyc;
    push_exp(F_A, 2'd0, c0 + 2);
    push_exp(F_B, 2'd1, c0 + 33);
    pulse_start(1'b0);
    while (cyc < c0 + 10) tick();
    rst = 1'b0;
    tick();
    checks++; if (pixels !== 64'h0 || busy !== 1'b0 || frame_stb !== 1'b0) begin errors++; $display("FAIL midrst_out: pixels %h busy %b stb %b, required 0 0 0", pixels, busy, frame_stb); end
    checks++; if (frame_idx !== 2'd0 || wr_ready !== 1'b0) begin errors++; $display("FAIL midrst_idx: idx %0d wr_ready %b, required 0 and 0", frame_idx, wr_ready); end
    rst = 1'b1;
    exp_q.delete();
    base = stb_count;
    tick();
    write_frame(F_C, 16'd1, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL midrst_write: accepted=%b, required 1", acc); end
    c0 = cyc;
    push_exp(F_C, 2'd0, c0 + 2);
    pulse_start(1'b0);
    wait_not_busy(100, ok, at);
    checks++; if (!ok || at != c0 + 12) begin errors++; $display("FAIL midrst_end: ok=%0d busy fell at %0d, required %0d", ok, at, c0 + 12); end
    tick();
    checks++; if (pixels !== F_C || stb_count - base != 1 || exp_q.size() != 0) begin errors++; $display("FAIL midrst_play: pix %h stb delta %0d pending %0d, required %h 1 0", pixels, stb_count - base, exp_q.size(), F_C); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop_stop();
    test_full_busy();
    test_empty_clear();
    test_mid_reset();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
